// File: rtl/addsub_serial_acc.sv
// Digit-serial add/subtract unit with accumulator and start/ready handshake.
// Define ADDSUB_SATURATE_EN to clamp overflowing results instead of wrapping.
module addsub_serial_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [1:0]       iOP,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCLR_ACC,
  output logic             oREADY,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [WIDTH-1:0] oRESULT,
  output logic             oCARRY,
  output logic             oOVF,
  output logic             oZERO,
  output logic [WIDTH-1:0] oACC
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, sum_q;
  logic [WIDTH-1:0] res_q, acc_q;
  logic             c_q, op1_q;
  logic             xmsb_q, ymsb_q;
  logic             carry_q, ovf_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       sum_d, res_d;
  logic [WIDTH-1:0]       x_d, y_d;
  logic                   ovf_d, last;

  assign dsum  = {1'b0, x_q[DIGIT-1:0]}
               + {1'b0, y_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, c_q};
  // New digit enters from the MSB side; the concat keeps DIGIT==WIDTH legal.
  assign cat   = {dsum[DIGIT-1:0], sum_q};
  assign sum_d = cat[WIDTH+DIGIT-1:DIGIT];
  assign ovf_d = (xmsb_q == ymsb_q)
              && (sum_d[WIDTH-1] != xmsb_q);
  assign last  = (cnt_q == CW'(N - 1));

`ifdef ADDSUB_SATURATE_EN
  assign res_d = !ovf_d ? sum_d :
                 xmsb_q ? {1'b1, {(WIDTH-1){1'b0}}} :
                          {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_d = sum_d;
`endif

  assign x_d = iOP[1] ? acc_q : iA;
  assign y_d = (iOP[1] ? iA : iB) ^ {WIDTH{iOP[0]}};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      op1_q   <= 1'b0;
      xmsb_q  <= 1'b0;
      ymsb_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Clear beats the write-back of an accumulate result.
      if (iCLR_ACC)
        acc_q <= '0;
      else if (state_q == DONE && op1_q)
        acc_q <= res_q;

      unique case (state_q)
        IDLE: begin
          if (iSTART) begin
            x_q     <= x_d;
            y_q     <= y_d;
            xmsb_q  <= x_d[WIDTH-1];
            ymsb_q  <= y_d[WIDTH-1];
            c_q     <= iOP[0];
            op1_q   <= iOP[1];
            sum_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q   <= x_q >> DIGIT;
          y_q   <= y_q >> DIGIT;
          c_q   <= dsum[DIGIT];
          sum_q <= sum_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            res_q   <= res_d;
            carry_q <= dsum[DIGIT];
            ovf_q   <= ovf_d;
            zero_q  <= (res_d == '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oREADY  = (state_q == IDLE);
  assign oBUSY   = (state_q != IDLE);
  assign oDONE   = (state_q == DONE);
  assign oRESULT = res_q;
  assign oCARRY  = carry_q;
  assign oOVF    = ovf_q;
  assign oZERO   = zero_q;
  assign oACC    = acc_q;

endmodule

// File: tb/tb_addsub_serial_acc.sv
// Self-checking bench for addsub_serial_acc (WIDTH=8, DIGIT=2).
// Vector table, hand sequences and a random run against an arithmetic model.
module tb_addsub_serial_acc;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         iRST, iSTART, iCLR_ACC;
  logic [1:0]   iOP;
  logic [W-1:0] iA, iB;
  logic         oREADY, oBUSY, oDONE;
  logic [W-1:0] oRESULT, oACC;
  logic         oCARRY, oOVF, oZERO;

  always #5 clk = ~clk;

  addsub_serial_acc #(.WIDTH(W), .DIGIT(D)) dut (
    .iCLK    (clk),
    .iRST    (iRST),
    .iSTART  (iSTART),
    .iOP     (iOP),
    .iA      (iA),
    .iB      (iB),
    .iCLR_ACC(iCLR_ACC),
    .oREADY  (oREADY),
    .oBUSY   (oBUSY),
    .oDONE   (oDONE),
    .oRESULT (oRESULT),
    .oCARRY  (oCARRY),
    .oOVF    (oOVF),
    .oZERO   (oZERO),
    .oACC    (oACC)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] macc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Signed/unsigned integer arithmetic, independent of the digit-serial datapath.
  function automatic void model(input logic [1:0] op, input int a, input int b,
                                input int acc, output int r, output int c,
                                output int v);
    int x, y, sx, sy, sr;
    x  = op[1] ? acc : a;
    y  = op[1] ? a : b;
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    if (op[0]) begin
      sr = sx - sy;
      c  = (x >= y) ? 1 : 0;
      r  = (x - y + 256) % 256;
    end else begin
      sr = sx + sy;
      c  = (x + y > 255) ? 1 : 0;
      r  = (x + y) % 256;
    end
    v = (sr > 127 || sr < -128) ? 1 : 0;
`ifdef ADDSUB_SATURATE_EN
    if (v == 1) r = (sr > 127) ? 'h7F : 'h80;
`endif
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit clr_done,
                        output int rr, output int rc, output int rv,
                        output int rz);
    int er, ec, ev, lat;
    bit rdy_low;
    model(op, int'(a), int'(b), int'(macc), er, ec, ev);
    @(negedge clk);
    chk("ready_before_start", int'(oREADY), 1);
    iOP = op; iA = a; iB = b; iSTART = 1'b1;
    @(negedge clk);
    iSTART = 1'b0;
    iA = W'($urandom); iB = W'($urandom); iOP = 2'($urandom);
    lat = 1;
    rdy_low = 1'b1;
    while (!oDONE && lat < 20) begin
      if (oREADY) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (oREADY) rdy_low = 1'b0;
    chk("done_latency", lat, N + 1);
    chk("ready_low_while_busy", int'(rdy_low), 1);
    chk("busy_in_done", int'(oBUSY), 1);
    rr = int'(oRESULT); rc = int'(oCARRY);
    rv = int'(oOVF);    rz = int'(oZERO);
    chk("result", rr, er);
    chk("carry", rc, ec);
    chk("ovf", rv, ev);
    chk("zero", rz, (er == 0) ? 1 : 0);
    iCLR_ACC = clr_done;
    @(negedge clk);
    iCLR_ACC = 1'b0;
    if (clr_done) macc = '0;
    else if (op[1]) macc = W'(er);
    chk("acc_after_op", int'(oACC), int'(macc));
    chk("done_one_cycle", int'(oDONE), 0);
    chk("ready_after_done", int'(oREADY), 1);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, r;
    logic         c, v, z;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int rr, rc, rv, rz;
    int nd, first, second, r1, r2;

    tbl[0] = '{2'b00, 8'h25, 8'h13, 8'h38, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SATURATE_EN
    tbl[2] = '{2'b00, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    tbl[2] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif
    tbl[3] = '{2'b01, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2'b01, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1};

    iRST = 1'b1; iSTART = 1'b0; iCLR_ACC = 1'b0;
    iOP = '0; iA = '0; iB = '0;
    macc = '0;
    repeat (2) @(negedge clk);
    iRST = 1'b0;
    chk("rst_ready", int'(oREADY), 1);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_done", int'(oDONE), 0);
    chk("rst_result", int'(oRESULT), 0);
    chk("rst_flags", int'({oCARRY, oOVF, oZERO}), 0);
    chk("rst_acc", int'(oACC), 0);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, rr, rc, rv, rz);
      chk($sformatf("tbl%0d_result", i), rr, int'(tbl[i].r));
      chk($sformatf("tbl%0d_carry", i), rc, int'(tbl[i].c));
      chk($sformatf("tbl%0d_ovf", i), rv, int'(tbl[i].v));
      chk($sformatf("tbl%0d_zero", i), rz, int'(tbl[i].z));
    end

    // iSTART held high: one op per N+2 cycles, operands sampled only in IDLE.
    @(negedge clk);
    iOP = 2'b00; iA = 8'h03; iB = 8'h04; iSTART = 1'b1;
    nd = 0; first = -1; second = -1; r1 = -1; r2 = -1;
    for (int c = 1; c <= 2 * (N + 2); c++) begin
      @(negedge clk);
      if (c == 1) iA = 8'h09;
      if (oDONE) begin
        nd++;
        if (nd == 1) begin first = c; r1 = int'(oRESULT); end
        else begin second = c; r2 = int'(oRESULT); end
      end
      if (c == 2 * (N + 2)) iSTART = 1'b0;
    end
    chk("hold_done_count", nd, 2);
    chk("hold_first_at", first, N + 1);
    chk("hold_second_at", second, 2 * (N + 2) - 1);
    chk("hold_first_res", r1, 'h07);
    chk("hold_second_res", r2, 'h0D);

    // Accumulator sequence.
    @(negedge clk);
    iCLR_ACC = 1'b1;
    @(negedge clk);
    iCLR_ACC = 1'b0;
    macc = '0;
    chk("acc_clear", int'(oACC), 0);
    for (int i = 0; i < 3; i++)
      run_op(2'b10, 8'h05, 8'hAA, 1'b0, rr, rc, rv, rz);
    chk("acc_three_adds", int'(oACC), 'h0F);
    run_op(2'b11, 8'h0F, 8'h55, 1'b0, rr, rc, rv, rz);
    chk("acc_sub_to_zero", int'(oACC), 0);
    chk("acc_sub_zero_flag", rz, 1);
    run_op(2'b10, 8'h22, 8'h00, 1'b0, rr, rc, rv, rz);
    chk("acc_load_22", int'(oACC), 'h22);
    run_op(2'b10, 8'h11, 8'h00, 1'b1, rr, rc, rv, rz);
    chk("acc_clr_in_done", int'(oACC), 0);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
             ($urandom_range(0, 7) == 0), rr, rc, rv, rz);

    // Reset during RUN cycle 2: no done, everything cleared.
    @(negedge clk);
    iOP = 2'b00; iA = 8'h40; iB = 8'h40; iSTART = 1'b1;
    @(negedge clk);
    iSTART = 1'b0;
    @(negedge clk);
    iRST = 1'b1;
    @(negedge clk);
    iRST = 1'b0;
    macc = '0;
    chk("abort_ready", int'(oREADY), 1);
    chk("abort_busy", int'(oBUSY), 0);
    chk("abort_result", int'(oRESULT), 0);
    chk("abort_flags", int'({oCARRY, oOVF, oZERO}), 0);
    chk("abort_acc", int'(oACC), 0);
    nd = 0;
    for (int c = 0; c < 2 * (N + 2); c++) begin
      if (oDONE) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    run_op(2'b00, 8'h01, 8'h01, 1'b0, rr, rc, rv, rz);
    chk("post_abort_add", rr, 'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial_acc.md
Name: addsub_serial_acc

Overview:
Parametrised, digit-serial add/subtract unit with an internal accumulator. It succeeds the fixed 4-bit switch-driven adder/subtractor. Operands are accepted through a start/ready handshake and processed DIGIT bits per clock. The unit reports the result with carry, overflow and zero flags and a one-cycle done pulse. It sits between switch/register sources and LED/7-segment display logic in board top levels.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits; must be ≥2.
DIGIT, 2, bits processed per RUN cycle; WIDTH % DIGIT must be 0; DIGIT==WIDTH is legal.

Ports:
iCLK  input  1  system clock; all state updates on the rising edge.
iRST  input  1  synchronous, active-high reset.
iSTART  input  1  request; sampled only when oREADY=1.
iOP  input  2  00 A+B, 01 A−B, 10 ACC+A, 11 ACC−A.
iA  input  WIDTH  operand A.
iB  input  WIDTH  operand B; ignored for iOP[1]=1.
iCLR_ACC  input  1  clears the accumulator.
oREADY  output  1  high in IDLE.
oBUSY  output  1  high in RUN and DONE.
oDONE  output  1  one-cycle pulse, high while in DONE.
oRESULT  output  WIDTH  last completed result; held until the next DONE.
oCARRY  output  1  carry-out; for subtraction, 1 = no borrow.
oOVF  output  1  two's-complement overflow of the last result.
oZERO  output  1  last result == 0.
oACC  output  WIDTH  accumulator contents.

Behaviour:
- Clock and reset: one clock, iCLK. iRST is synchronous and active-high.
- Reset: state←IDLE. oRESULT, oCARRY, oOVF, oZERO, oACC, the cycle counter and operand shift registers ←0. oDONE=0, oBUSY=0, oREADY=1 after the reset edge.
- iRST has priority over every other input, including mid-RUN. An aborted operation produces no oDONE and no accumulator update.
- FSM states: IDLE, RUN, DONE.
  - IDLE: oREADY=1. On iSTART=1, latch the operands:
    - X = iOP[1] ? ACC : iA.
    - Y = iOP[1] ? iA : iB; Y is inverted when iOP[0]=1.
    - carry-in = iOP[0]; latch iOP; counter←0; go to RUN.
  - RUN: each cycle, add the low DIGIT bits of X, Y and the carry. Shift the sum slice into the result register from the MSB side; shift X and Y right by DIGIT. Counter increments. After N = WIDTH/DIGIT RUN cycles go to DONE.
  - DONE: oRESULT, oCARRY, oOVF, oZERO update on entry; oDONE=1 for exactly this one cycle. If the latched iOP[1]=1, ACC←result. Next state is IDLE.
- Latency: iSTART accepted at edge 0 → oDONE high during cycle N+1; next iSTART can be accepted at edge N+2. Throughput is one operation per N+2 cycles.
- Flag rules:
  - oCARRY = final carry-out.
  - oOVF = (X[MSB]==Y'[MSB]) && (sum[MSB]!=X[MSB]), where Y' is the possibly inverted operand.
  - oZERO = (final oRESULT == 0), evaluated after any saturation.
- Arithmetic wraps modulo 2^WIDTH unless the optional feature is compiled in.
- iSTART while oBUSY=1 is ignored; nothing is queued. iA, iB and iOP may change freely after acceptance.
- iCLR_ACC: ACC←0 on any non-reset cycle.
  - If it coincides with a DONE accumulator write, the clear wins.
  - A clear during RUN does not affect the operand X already latched.
- Flags and oRESULT are not modified by iCLR_ACC.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined: on oOVF=1, the result is clamped before it reaches oRESULT and ACC:
  - X[MSB]=0 → 0111…1 (max positive).
  - X[MSB]=1 → 1000…0 (min negative).
  - oOVF is still reported as 1; oCARRY reports the raw carry.
- Undefined: results wrap; no clamp logic is synthesised.

Test Plan:
1. WIDTH=8, DIGIT=2, after reset: iOP=00, A=0x25, B=0x13, iSTART pulse → oDONE exactly 5 cycles after acceptance; oRESULT=0x38, oCARRY=0, oOVF=0, oZERO=0; oREADY=0 for 5 cycles.
2. ADD 0xFF+0x01 → 0x00, oCARRY=1, oZERO=1, oOVF=0. ADD 0x7F+0x01 → 0x80, oOVF=1; with ADDSUB_SATURATE_EN → 0x7F, oOVF=1.
3. SUB 0x10−0x20 → 0xF0, oCARRY=0, oOVF=0. SUB 0x80−0x01 → 0x7F, oOVF=1; with ADDSUB_SATURATE_EN → 0x80.
4. Accumulator sequence: iCLR_ACC, then iOP=10 with A=0x05 three times → oACC=0x0F. Then iOP=11 with A=0x0F → oACC=0x00, oZERO=1. iCLR_ACC asserted in a DONE cycle of iOP=10 → oACC=0x00.
5. iSTART held high throughout an operation → exactly one oDONE per N+2 cycles, with no operand re-sampling while busy.
6. iRST for one cycle at RUN cycle 2 → next cycle IDLE with all outputs zero and oREADY=1; no oDONE is produced; a subsequent ADD 0x01+0x01 → 0x02.
